ctrl_word_executor: RTL
=======================

Name: ctrl_word_executor

Overview:
- Decodes packed control words arriving over a valid/ready command channel.
- Drives the datapath's select and write-enable inputs for each word, samples the datapath's four status flags, and returns them on a valid/ready response channel.
- Sits between an external microcode source (host loader or ROM sequencer) and the datapath. It is the consuming end of the control/flag interface that the hardwired Fibonacci controller currently originates.

Parameters:
- SEL_W, 2, width of each of the four select fields (sr, multa, alu, multb).
- WR_W, 4, width of the writer (register write-enable) field.
- SETTLE, 2, cycles selects are held before flags are sampled; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_word  in  4*SEL_W+WR_W  packed word, MSB to LSB: {writer, multb, alu, multa, sr}.
- cmd_valid  in  1  cmd_word is valid.
- cmd_ready  out  1  block can accept a word.
- rsp_flags  out  4  captured flags, {fov, fcarry, fneg, fzero}.
- rsp_valid  out  1  rsp_flags is valid.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.
- selection_sr, selection_multa, selection_alu, selection_multb  out  SEL_W each  datapath selects.
- writer  out  WR_W  datapath register write enables.
- fov, fcarry, fneg, fzero  in  1 each  datapath flags.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - On rst, all outputs go to 0 and the state goes to IDLE. cmd_ready rises in the first cycle after rst deasserts.
- States: IDLE, EXEC, COMMIT, RESP.
- IDLE:
  - cmd_ready=1; selects=0; writer=0.
  - cmd_valid&cmd_ready at edge T: latch cmd_word, load settle counter with SETTLE-1, go to EXEC.
- EXEC:
  - cmd_ready=0; selects driven from the latched word; writer=0.
  - Counter decrements each cycle. At 0, sample the four flags into rsp_flags and go to COMMIT.
  - EXEC lasts exactly SETTLE cycles (T+1..T+SETTLE).
- COMMIT:
  - Selects held; writer = latched writer field for exactly one cycle (T+SETTLE+1); then go to RESP.
  - writer is never nonzero in any other state.
- RESP:
  - Selects return to 0; rsp_valid=1. rsp_flags is held stable until rsp_valid&rsp_ready.
  - On the handshake, go to IDLE; cmd_ready rises the next cycle.
  - No combinational path from rsp_ready to cmd_ready.
- Throughput and latency:
  - One word per SETTLE+3 cycles minimum.
  - Latency from command acceptance to rsp_valid is SETTLE+2 cycles.
- Flag sampling: flags are sampled before the write commits, i.e. they reflect the ALU result that is being written.
- Boundary conditions:
  - cmd_valid outside IDLE is ignored; the word must be held by the source.
  - rsp_ready asserted in the same cycle rsp_valid rises completes the handshake in that cycle.
  - Reset in COMMIT forces writer=0 immediately (asynchronous); the partial write is the datapath's concern.
  - Counter reload uses only the low 4 bits of SETTLE.
- Registered outputs: all outputs except busy are registered. busy = (state != IDLE), decoded from the state register.

Optional Feature:
- Macro: CTRL_WORD_EXECUTOR_STICKY_FLAGS_EN.
- When defined:
  - Adds input clr_sticky (1 bit) and output sticky_flags (4 bits, reset 0).
  - At each EXEC-to-COMMIT sample, sticky_flags |= sampled flags.
  - clr_sticky=1 zeros sticky_flags on the next edge. If clr_sticky coincides with a sample, the result is the new sample only.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package (datapath_pkg): state encoding constants (IDLE=0, EXEC=1, COMMIT=2, RESP=3), flag bit indices (FOV=3, FCARRY=2, FNEG=1, FZERO=0), and the cmd_word field offsets derived from SEL_W/WR_W.
- One natural sub-module: settle_counter (load, decrement, zero flag). The FSM and field slicing stay in the top.

Test Plan:
- Reset: assert rst mid-EXEC with word 0x123 -> all outputs 0 within the same cycle; cmd_ready=1 the first cycle after deassert.
- Single word: SETTLE=2, cmd_word=12'hF_1B (writer=F, multb=0, alu=1, multa=2, sr=3), flags held 4'b0101:
  - Selects visible T+1..T+3.
  - writer=F only at T+3.
  - rsp_valid at T+4 with rsp_flags=0101.
- Back-pressure: hold rsp_ready=0 for 10 cycles while flags change to 1010 -> rsp_flags stays 0101; cmd_ready stays 0; second word not accepted.
- Back-to-back: cmd_valid held high with two words, rsp_ready=1 -> second acceptance exactly SETTLE+3=5 cycles after the first; writer pulses exactly twice.
- Flag timing: flags 0000 during EXEC, switching to 1000 only in the COMMIT cycle -> rsp_flags=0000.
- Sticky (macro defined): three words with flags 0001, 0100, 0000 -> sticky_flags=0101; pulse clr_sticky -> 0000.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the control-word executor: FSM state encoding,
// status-flag bit positions and control-word field offsets.
package datapath_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Bit positions inside the packed {fov, fcarry, fneg, fzero} flag vector
    localparam int FOV    = 3;
    localparam int FCARRY = 2;
    localparam int FNEG   = 1;
    localparam int FZERO  = 0;

    // Field order inside cmd_word, LSB first: sr, multa, alu, multb, writer
    localparam int FLD_SR     = 0;
    localparam int FLD_MULTA  = 1;
    localparam int FLD_ALU    = 2;
    localparam int FLD_MULTB  = 3;
    localparam int FLD_WRITER = 4;

    function automatic int field_off(input int fld, input int sel_w);
        return fld * sel_w;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter that times how long the datapath selects are held before
// the status flags are sampled. Loads a value, decrements to zero, then stops.
module settle_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/ctrl_word_executor.sv
// Executes one packed control word at a time: drives selects, pulses the
// register write enables, and returns the sampled flags on a response channel.
// Optional sticky flag accumulation: CTRL_WORD_EXECUTOR_STICKY_FLAGS_EN.
module ctrl_word_executor
    import datapath_pkg::*;
#(
    parameter int SEL_W  = 2,
    parameter int WR_W   = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*SEL_W+WR_W-1:0] cmd_word,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  busy,
    output logic [SEL_W-1:0]      selection_sr,
    output logic [SEL_W-1:0]      selection_multa,
    output logic [SEL_W-1:0]      selection_alu,
    output logic [SEL_W-1:0]      selection_multb,
    output logic [WR_W-1:0]       writer,
    input  logic                  fov,
    input  logic                  fcarry,
    input  logic                  fneg,
    input  logic                  fzero
`ifdef CTRL_WORD_EXECUTOR_STICKY_FLAGS_EN
    ,
    input  logic                  clr_sticky,
    output logic [3:0]            sticky_flags
`endif
);

    localparam int OFF_SR    = field_off(FLD_SR, SEL_W);
    localparam int OFF_MULTA = field_off(FLD_MULTA, SEL_W);
    localparam int OFF_ALU   = field_off(FLD_ALU, SEL_W);
    localparam int OFF_MULTB = field_off(FLD_MULTB, SEL_W);
    localparam int OFF_WR    = field_off(FLD_WRITER, SEL_W);

    // Only the low nibble of SETTLE is meaningful to the 4-bit counter
    localparam logic [3:0] SETTLE_LO   = SETTLE[3:0];
    localparam logic [3:0] SETTLE_LOAD = SETTLE_LO - 4'd1;

    state_t          state_reg;
    logic [WR_W-1:0] wr_hold_reg;
    logic [3:0]      flags_now;
    logic            accept;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic            sample;

    always_comb begin
        flags_now         = 4'd0;
        flags_now[FOV]    = fov;
        flags_now[FCARRY] = fcarry;
        flags_now[FNEG]   = fneg;
        flags_now[FZERO]  = fzero;
    end

    assign accept   = (state_reg == IDLE) && cmd_valid && cmd_ready;
    assign cnt_load = accept;
    assign cnt_dec  = (state_reg == EXEC) && !cnt_zero;
    assign sample   = (state_reg == EXEC) && cnt_zero;
    assign busy     = (state_reg != IDLE);

    settle_counter u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cmd_ready       <= 1'b0;
            rsp_flags       <= 4'd0;
            rsp_valid       <= 1'b0;
            selection_sr    <= '0;
            selection_multa <= '0;
            selection_alu   <= '0;
            selection_multb <= '0;
            writer          <= '0;
            wr_hold_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready       <= 1'b0;
                        selection_sr    <= cmd_word[OFF_SR +: SEL_W];
                        selection_multa <= cmd_word[OFF_MULTA +: SEL_W];
                        selection_alu   <= cmd_word[OFF_ALU +: SEL_W];
                        selection_multb <= cmd_word[OFF_MULTB +: SEL_W];
                        wr_hold_reg     <= cmd_word[OFF_WR +: WR_W];
                        state_reg       <= EXEC;
                    end
                end
                EXEC: begin
                    // Flags are taken before the write lands, so they describe the value being written
                    if (cnt_zero) begin
                        rsp_flags <= flags_now;
                        writer    <= wr_hold_reg;
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    writer          <= '0;
                    selection_sr    <= '0;
                    selection_multa <= '0;
                    selection_alu   <= '0;
                    selection_multb <= '0;
                    rsp_valid       <= 1'b1;
                    state_reg       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef CTRL_WORD_EXECUTOR_STICKY_FLAGS_EN
    // A clear that lands on a sample keeps just the fresh sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= 4'd0;
        end else if (clr_sticky) begin
            sticky_flags <= sample ? flags_now : 4'd0;
        end else if (sample) begin
            sticky_flags <= sticky_flags | flags_now;
        end
    end
`endif

endmodule
